// File: rtl/fifo_8_16.sv
// Eight-entry, 16-bit first-word-fall-through FIFO with a combinational mux read port.
// Define FIFO_8_16_LEVEL_EN to expose the occupancy on the `level` port.

module mux_8_way_16 (
  input  logic [127:0] in,
  input  logic [2:0]   sel,
  output logic [15:0]  out
);

  always_comb begin
    out = 16'h0000;
    unique case (sel)
      3'd0: out = in[0*16 +: 16];
      3'd1: out = in[1*16 +: 16];
      3'd2: out = in[2*16 +: 16];
      3'd3: out = in[3*16 +: 16];
      3'd4: out = in[4*16 +: 16];
      3'd5: out = in[5*16 +: 16];
      3'd6: out = in[6*16 +: 16];
      3'd7: out = in[7*16 +: 16];
      default: out = 16'h0000;
    endcase
  end

endmodule

module fifo_8_16 (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out,
  output logic        out_valid,
  input  logic        out_ready
`ifdef FIFO_8_16_LEVEL_EN
  ,
  output logic [3:0]  level
`endif
);

  logic [127:0] slots;
  logic [2:0]   wr_ptr;
  logic [2:0]   rd_ptr;
  logic [3:0]   count;
  logic         push;
  logic         pop;

  // Handshake flags depend only on state, so out_ready never reaches in_ready.
  assign in_ready  = (count != 4'd8);
  assign out_valid = (count != 4'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

`ifdef FIFO_8_16_LEVEL_EN
  assign level = count;
`endif

  mux_8_way_16 u_read_mux (
    .in  (slots),
    .sel (rd_ptr),
    .out (out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slots  <= '0;
      wr_ptr <= 3'd0;
      rd_ptr <= 3'd0;
      count  <= 4'd0;
    end else begin
      if (push) begin
        slots[{wr_ptr, 4'b0000} +: 16] <= in;
        wr_ptr <= wr_ptr + 3'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 3'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_8_16.sv
// Scoreboard bench for fifo_8_16: checks order, handshake flags and occupancy against a queue.
// Level checks are compiled in only when FIFO_8_16_LEVEL_EN is defined.

module tb_fifo_8_16;

  logic        clk;
  logic        reset;
  logic [15:0] in;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out;
  logic        out_valid;
  logic        out_ready;
`ifdef FIFO_8_16_LEVEL_EN
  logic [3:0]  level;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [15:0] mq[$];
  int          mcount = 0;

  fifo_8_16 dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef FIFO_8_16_LEVEL_EN
    ,
    .level     (level)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle and advance the model; returns #1 after the edge.
  task automatic cycle(input logic iv, input logic [15:0] d, input logic ordy);
    logic mpush;
    logic mpop;
    in        = d;
    in_valid  = iv;
    out_ready = ordy;
    mpush = iv && (mcount != 8);
    mpop  = ordy && (mcount != 0);
    @(posedge clk);
    #1;
    if (mpop) void'(mq.pop_front());
    if (mpush) mq.push_back(d);
    mcount = mcount + (mpush ? 1 : 0) - (mpop ? 1 : 0);
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in        = 16'h0000;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_idle: out_valid=%b in_ready=%b out=%h, required 0 1 0000",
               out_valid, in_ready, out);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'h5500 + 16'(i), 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out !== 16'h5500) begin
      n_fail++;
      $display("FAIL reset_prefill: out_valid=%b out=%h, required 1 5500", out_valid, out);
    end
    idle_inputs();
    reset = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_midstream: out_valid=%b in_ready=%b out=%h, required 0 1 0000",
               out_valid, in_ready, out);
    end
`ifdef FIFO_8_16_LEVEL_EN
    n_checks++;
    if (level !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_level: level=%0d, required 0", level);
    end
`endif
    mq.delete();
    mcount = 0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    cycle(1'b1, 16'h1111, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out !== mq[0]) begin
      n_fail++;
      $display("FAIL single_push: out_valid=%b out=%h, required 1 %h", out_valid, out, mq[0]);
    end
`ifdef FIFO_8_16_LEVEL_EN
    n_checks++;
    if (level !== 4'd1) begin
      n_fail++;
      $display("FAIL single_level: level=%0d, required 1", level);
    end
`endif
    cycle(1'b0, 16'h0000, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_pop: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 8; i++) cycle(1'b1, 16'hA000 + 16'(i), 1'b0);
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_full: in_ready=%b out_valid=%b, required 0 1", in_ready, out_valid);
    end
    cycle(1'b1, 16'hFFFF, 1'b0);
    n_checks++;
    if (in_ready !== 1'b0 || mcount != 8) begin
      n_fail++;
      $display("FAIL fill_drop: in_ready=%b model_count=%0d, required 0 8", in_ready, mcount);
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out !== mq[0]) begin
        n_fail++;
        $display("FAIL drain_word%0d: out_valid=%b out=%h, required 1 %h",
                 i, out_valid, out, mq[0]);
      end
      cycle(1'b0, 16'h0000, 1'b1);
    end
    n_checks++;
    if (out_valid !== 1'b0 || mq.size() != 0) begin
      n_fail++;
      $display("FAIL drain_empty: out_valid=%b queue=%0d, required 0 0", out_valid, mq.size());
    end
  endtask

  task automatic test_full_simul();
    for (int i = 0; i < 8; i++) cycle(1'b1, 16'hB000 + 16'(i), 1'b0);
    n_checks++;
    if (out !== mq[0]) begin
      n_fail++;
      $display("FAIL full_head: out=%h, required %h", out, mq[0]);
    end
    cycle(1'b1, 16'hCCCC, 1'b1);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || out !== mq[0] || mcount != 7) begin
      n_fail++;
      $display("FAIL full_simul: in_ready=%b out=%h model_count=%0d, required 1 %h 7",
               in_ready, out, mcount, mq[0]);
    end
`ifdef FIFO_8_16_LEVEL_EN
    n_checks++;
    if (level !== 4'd7) begin
      n_fail++;
      $display("FAIL full_simul_level: level=%0d, required 7", level);
    end
`endif
    while (mq.size() != 0) begin
      n_checks++;
      if (out !== mq[0]) begin
        n_fail++;
        $display("FAIL full_drain: out=%h, required %h", out, mq[0]);
      end
      cycle(1'b0, 16'h0000, 1'b1);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 200; i++) begin
      logic iv;
      logic ordy;
      iv   = 1'($urandom_range(0, 1));
      ordy = 1'($urandom_range(0, 1));
      n_checks++;
      if (out_valid !== (mcount != 0) || in_ready !== (mcount != 8) ||
          (mcount != 0 && out !== mq[0])) begin
        n_fail++;
        bad++;
        if (bad <= 5)
          $display("FAIL random_cycle%0d: out_valid=%b in_ready=%b out=%h, required %b %b %h",
                   i, out_valid, in_ready, out, mcount != 0, mcount != 8,
                   (mcount != 0) ? mq[0] : 16'h0000);
      end
`ifdef FIFO_8_16_LEVEL_EN
      n_checks++;
      if (level !== 4'(mcount)) begin
        n_fail++;
        $display("FAIL random_level%0d: level=%0d, required %0d", i, level, mcount);
      end
`endif
      cycle(iv, 16'(($urandom)), ordy);
    end
    while (mq.size() != 0) begin
      n_checks++;
      if (out !== mq[0]) begin
        n_fail++;
        $display("FAIL random_drain: out=%h, required %h", out, mq[0]);
      end
      cycle(1'b0, 16'h0000, 1'b1);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'hC000 + 16'(i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || out !== mq[0] || mcount != 3) begin
        n_fail++;
        $display("FAIL stream_cycle%0d: out=%h out_valid=%b in_ready=%b, required %h 1 1",
                 i, out, out_valid, in_ready, mq[0]);
      end
`ifdef FIFO_8_16_LEVEL_EN
      n_checks++;
      if (level !== 4'd3) begin
        n_fail++;
        $display("FAIL stream_level%0d: level=%0d, required 3", i, level);
      end
`endif
      cycle(1'b1, 16'hD000 + 16'(i), 1'b1);
    end
    // With three words buffered, the head is the word pushed three cycles earlier.
    n_checks++;
    if (out !== 16'hD011) begin
      n_fail++;
      $display("FAIL stream_lag: out=%h, required d011", out);
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_fill_drain();
    test_full_simul();
    test_random();
    test_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
